// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the AG1/AG2/MEM/EX/WB pipeline controller: stage indices,
// scoreboard tag numbering and the counter-width helper.
package pipe_hazard_ctrl_pkg;

    typedef enum int {
        STG_AG1 = 0,
        STG_AG2 = 1,
        STG_MEM = 2,
        STG_EX  = 3,
        STG_WB  = 4
    } stage_e;

    localparam int TAG_EFLAGS = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int DEF_NUM_STAGES = int'(STG_WB) + 1;
    localparam int DEF_NUM_REGS   = TAG_EFLAGS + 1;
    localparam int DEF_TAG_W      = 4;
    localparam int DEF_MEM_STAGE  = int'(STG_MEM);
    localparam int DEF_EXEC_STAGE = int'(STG_EX);
    // One count per possible in-flight writer plus zero.
    localparam int CNT_W          = clog2(DEF_NUM_STAGES + 1);

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Issue/control bundle between the decoder/datapath (master) and the hazard controller (slave).
// Issue handshake: an instruction is accepted in a cycle where i_issue_vld & o_issue_rdy are
// both high; o_issue_rdy never depends on i_issue_vld, and the master holds its fields stable while vld.
interface pipe_hazard_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_REGS   = 9,
    parameter int TAG_W      = 4,
    parameter int CNT_W      = 3
);
    logic                           i_issue_vld;
    logic [TAG_W-1:0]               i_src1;
    logic [TAG_W-1:0]               i_src2;
    logic                           i_src1_rd;
    logic                           i_src2_rd;
    logic [TAG_W-1:0]               i_dst;
    logic                           i_dst_we;
    logic                           i_mem_stall;
    logic                           i_flush;

    logic                           o_issue_rdy;
    logic [NUM_STAGES-1:0]          o_stage_vld;
    logic [NUM_STAGES-1:0]          o_stage_ld;
    logic                           o_wb_we;
    logic [TAG_W-1:0]               o_wb_dst;
    // Scoreboard counts per tag, exposed for observation.
    logic [NUM_REGS-1:0][CNT_W-1:0] dbg_cnt;

    modport master (
        output i_issue_vld, i_src1, i_src2, i_src1_rd, i_src2_rd, i_dst, i_dst_we,
               i_mem_stall, i_flush,
        input  o_issue_rdy, o_stage_vld, o_stage_ld, o_wb_we, o_wb_dst, dbg_cnt
    );

    modport slave (
        input  i_issue_vld, i_src1, i_src2, i_src1_rd, i_src2_rd, i_dst, i_dst_we,
               i_mem_stall, i_flush,
        output o_issue_rdy, o_stage_vld, o_stage_ld, o_wb_we, o_wb_dst, dbg_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sb_counter.sv
// Scoreboard counter for one register tag: number of valid writers currently in flight.
// Increment and a multi-writer decrement may land in the same cycle.
module pipe_hazard_ctrl_sb_counter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic [CW-1:0] dec,
    output logic [CW-1:0] count,
    output logic          busy
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(inc) - dec;
        end
    end

    assign count = cnt_q;
    assign busy  = |cnt_q;

    // Removing more writers than are tracked means the stage bookkeeping is broken.
    no_underflow: assert property (@(posedge clk) disable iff (!rst)
        ({1'b0, cnt_q} + {{CW{1'b0}}, inc}) >= {1'b0, dec});

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the AG1/AG2/MEM/EX/WB datapath: per-stage valid/tag tracking,
// latch enables, RAW scoreboard at issue, MEM back-pressure and EX-driven flush.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int MEM_STAGE  = DEF_MEM_STAGE,
    parameter int EXEC_STAGE = DEF_EXEC_STAGE
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int CW = clog2(NUM_STAGES + 1);

    logic [NUM_STAGES-1:0] vld_q;
    logic [NUM_STAGES-1:0] we_q;
    logic [TAG_W-1:0]      dst_q [NUM_STAGES];

    logic                  stall_act;
    logic                  flush_act;
    logic                  haz;
    logic                  issue_rdy;
    logic                  accept;
    logic                  retire;
    logic [NUM_STAGES-1:0] hold;

    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   inc;
    logic [CW-1:0]         dec [NUM_REGS];
    logic [CW-1:0]         cnt [NUM_REGS];

    // Tags outside the scoreboard are never busy.
    function automatic logic src_busy(input logic [TAG_W-1:0] tag,
                                      input logic [NUM_REGS-1:0] b);
        src_busy = 1'b0;
        for (int t = 0; t < NUM_REGS; t++) begin
            if (tag == TAG_W'(t)) src_busy = b[t];
        end
    endfunction

    assign stall_act = bus.i_mem_stall & vld_q[MEM_STAGE];
    assign flush_act = bus.i_flush & vld_q[EXEC_STAGE];

    // A flush squashes the stalled stages, so it also releases the hold.
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            hold[i] = stall_act & ~flush_act & (i <= MEM_STAGE);
        end
    end

    assign haz       = (bus.i_src1_rd & src_busy(bus.i_src1, busy)) |
                       (bus.i_src2_rd & src_busy(bus.i_src2, busy));
    assign issue_rdy = rst & ~haz & ~hold[0] & ~flush_act;
    assign accept    = bus.i_issue_vld & issue_rdy;
    assign retire    = vld_q[NUM_STAGES-1] & we_q[NUM_STAGES-1];

    // Per-tag decrement: the retiring writer plus every valid writer squashed by a flush.
    always_comb begin
        for (int t = 0; t < NUM_REGS; t++) begin
            inc[t] = accept & bus.i_dst_we & (bus.i_dst == TAG_W'(t));
            dec[t] = CW'(retire & (dst_q[NUM_STAGES-1] == TAG_W'(t)));
            for (int j = 0; j < EXEC_STAGE; j++) begin
                dec[t] = dec[t] + CW'(flush_act & vld_q[j] & we_q[j] &
                                      (dst_q[j] == TAG_W'(t)));
            end
        end
    end

    for (genvar t = 0; t < NUM_REGS; t++) begin : g_sb
        pipe_hazard_ctrl_sb_counter #(.CW(CW)) u_sb_counter (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc[t]),
            .dec   (dec[t]),
            .count (cnt[t]),
            .busy  (busy[t])
        );
    end

    always_comb begin
        for (int t = 0; t < NUM_REGS; t++) begin
            bus.dbg_cnt[t] = cnt[t];
        end
    end

    // Stage shift register. A held stage keeps its contents; the first unheld stage
    // behind a held one takes a bubble; stages ahead of EX are squashed on flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            we_q  <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                dst_q[i] <= '0;
            end
        end else begin
            if (!hold[0]) begin
                vld_q[0] <= accept;
                we_q[0]  <= accept & bus.i_dst_we;
                dst_q[0] <= bus.i_dst;
            end
            for (int i = 1; i < NUM_STAGES; i++) begin
                if (!hold[i]) begin
                    vld_q[i] <= vld_q[i-1] & ~hold[i-1] & ~(flush_act & (i <= EXEC_STAGE));
                    we_q[i]  <= we_q[i-1];
                    dst_q[i] <= dst_q[i-1];
                end
            end
        end
    end

    assign bus.o_issue_rdy = issue_rdy;
    assign bus.o_stage_vld = vld_q;
    assign bus.o_stage_ld  = {NUM_STAGES{rst}} & ~hold;
    assign bus.o_wb_we     = retire;
    assign bus.o_wb_dst    = dst_q[NUM_STAGES-1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: an instruction-level pipeline model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int NS  = 5;
    localparam int NR  = 9;
    localparam int TW  = 4;
    localparam int CW  = CNT_W;
    localparam int MEM = 2;
    localparam int EX  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.NUM_STAGES(NS), .NUM_REGS(NR), .TAG_W(TW), .CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(
        .NUM_STAGES(NS), .NUM_REGS(NR), .TAG_W(TW), .MEM_STAGE(MEM), .EXEC_STAGE(EX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    int wb_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- instruction-level model ----------------
    bit          m_vld [NS];
    bit          m_we  [NS];
    logic [TW-1:0] m_dst [NS];

    function automatic int inflight(input int tag);
        int n = 0;
        for (int i = 0; i < NS; i++)
            if (m_vld[i] && m_we[i] && int'(m_dst[i]) == tag) n++;
        return n;
    endfunction

    function automatic bit src_haz(input logic [TW-1:0] s, input logic rd);
        return rd && (int'(s) < NR) && (inflight(int'(s)) > 0);
    endfunction

    function automatic bit model_rdy();
        bit stall, fl;
        stall = bus.i_mem_stall && m_vld[MEM];
        fl    = bus.i_flush && m_vld[EX];
        return !src_haz(bus.i_src1, bus.i_src1_rd) && !src_haz(bus.i_src2, bus.i_src2_rd)
               && !stall && !fl;
    endfunction

    bit u_stall, u_fl, u_acc;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NS; i++) begin
                m_vld[i] = 0; m_we[i] = 0; m_dst[i] = '0;
            end
        end else begin
            u_stall = bus.i_mem_stall && m_vld[MEM];
            u_fl    = bus.i_flush && m_vld[EX];
            u_acc   = bus.i_issue_vld && model_rdy();
            if (u_fl) begin
                for (int i = NS - 1; i > 0; i--) begin
                    if (i > EX) begin
                        m_vld[i] = m_vld[i-1]; m_we[i] = m_we[i-1]; m_dst[i] = m_dst[i-1];
                    end else begin
                        m_vld[i] = 0; m_we[i] = 0; m_dst[i] = '0;
                    end
                end
                m_vld[0] = 0; m_we[0] = 0; m_dst[0] = '0;
            end else if (u_stall) begin
                for (int i = NS - 1; i > MEM + 1; i--) begin
                    m_vld[i] = m_vld[i-1]; m_we[i] = m_we[i-1]; m_dst[i] = m_dst[i-1];
                end
                m_vld[MEM+1] = 0; m_we[MEM+1] = 0; m_dst[MEM+1] = '0;
            end else begin
                for (int i = NS - 1; i > 0; i--) begin
                    m_vld[i] = m_vld[i-1]; m_we[i] = m_we[i-1]; m_dst[i] = m_dst[i-1];
                end
                m_vld[0] = u_acc;
                m_we[0]  = u_acc && bus.i_dst_we;
                m_dst[0] = u_acc ? bus.i_dst : '0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp
        bit c_stall, c_fl, e_rdy, e_wb;
        logic [NS-1:0] e_ld, e_vld;
        logic [NR*CW-1:0] e_cnt;
        if (bus.o_wb_we) wb_cnt++;
        if (chk_en) begin
            c_stall = bus.i_mem_stall && m_vld[MEM];
            c_fl    = bus.i_flush && m_vld[EX];
            e_rdy   = rst && model_rdy();
            for (int i = 0; i < NS; i++) begin
                e_ld[i]  = rst && !(c_stall && !c_fl && i <= MEM);
                e_vld[i] = m_vld[i];
            end
            for (int t = 0; t < NR; t++) e_cnt[t*CW +: CW] = CW'(inflight(t));
            e_wb = m_vld[NS-1] && m_we[NS-1];
            check("rdy", bus.o_issue_rdy, e_rdy);
            check("ld", bus.o_stage_ld, e_ld);
            check("vld", bus.o_stage_vld, e_vld);
            check("wb_we", bus.o_wb_we, e_wb);
            if (e_wb) check("wb_dst", bus.o_wb_dst, m_dst[NS-1]);
            check("cnt", bus.dbg_cnt, e_cnt);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.i_issue_vld = 0; bus.i_src1 = '0; bus.i_src2 = '0;
        bus.i_src1_rd = 0; bus.i_src2_rd = 0; bus.i_dst = '0; bus.i_dst_we = 0;
        bus.i_mem_stall = 0; bus.i_flush = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Offer one instruction until accepted; waits = cycles spent with rdy low.
    task automatic issue(input logic [TW-1:0] dst, input logic we,
                         input logic [TW-1:0] s1, input logic r1,
                         input logic [TW-1:0] s2, input logic r2, output int waits);
        bus.i_issue_vld = 1; bus.i_dst = dst; bus.i_dst_we = we;
        bus.i_src1 = s1; bus.i_src1_rd = r1; bus.i_src2 = s2; bus.i_src2_rd = r2;
        waits = 0;
        forever begin
            @(negedge clk);
            if (bus.o_issue_rdy) break;
            waits++;
            if (waits > 20) begin check("issue_timeout", 64'(waits), 0); break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.i_issue_vld = 0; bus.i_src1_rd = 0; bus.i_src2_rd = 0; bus.i_dst_we = 0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin : stim
        int w, wsum;
        idle_inputs();
        rst = 0;
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        check("rst_rdy", bus.o_issue_rdy, 0);
        check("rst_ld", bus.o_stage_ld, 0);
        tick(1);
        rst = 1;
        @(negedge clk);
        check("post_rst_rdy", bus.o_issue_rdy, 1);
        check("post_rst_vld", bus.o_stage_vld, 0);
        check("post_rst_ld", bus.o_stage_ld, 5'b11111);
        tick(1);

        // RAW on src1 and src2: writer sits 5 cycles in the pipe (incl. retire cycle)
        issue(4'd2, 1, 0, 0, 0, 0, w);
        issue(4'd5, 1, 4'd2, 1, 0, 0, w);
        check("raw_src1_waits", 64'(w), 5);
        tick(6);
        issue(4'd6, 1, 0, 0, 0, 0, w);
        issue(4'd7, 0, 0, 0, 4'd6, 1, w);
        check("raw_src2_waits", 64'(w), 5);
        tick(6);

        // Out-of-range tag never hazards; EFLAGS does; unread sources ignored
        issue(4'd15, 1, 0, 0, 0, 0, w);
        issue(4'd0, 0, 4'd15, 1, 0, 0, w);
        check("hi_tag_waits", 64'(w), 0);
        tick(6);
        issue(4'd8, 1, 0, 0, 0, 0, w);
        issue(4'd1, 0, 0, 0, 4'd8, 1, w);
        check("eflags_waits", 64'(w), 5);
        tick(6);
        issue(4'd4, 1, 0, 0, 0, 0, w);
        issue(4'd0, 0, 4'd4, 0, 4'd4, 0, w);
        check("unread_waits", 64'(w), 0);
        tick(6);

        // Independent stream of 10
        wb_cnt = 0; wsum = 0;
        for (int i = 0; i < 10; i++) begin
            issue(TW'(i % 8), 1, TW'((i + 1) % 8), 1, TW'((i + 2) % 8), 1, w);
            wsum += w;
        end
        check("stream_waits", 64'(wsum), 0);
        check("stream_wb_early", 64'(wb_cnt), 5);
        tick(5);
        check("stream_wb_total", 64'(wb_cnt), 10);
        tick(2);

        // MEM stall for 2 cycles with stages 0..2 valid
        issue(4'd1, 1, 0, 0, 0, 0, w);
        issue(4'd2, 1, 0, 0, 0, 0, w);
        issue(4'd3, 1, 0, 0, 0, 0, w);
        bus.i_mem_stall = 1;
        @(negedge clk);
        check("stall_rdy", bus.o_issue_rdy, 0);
        check("stall_ld", bus.o_stage_ld, 5'b11000);
        tick(1);
        @(negedge clk);
        check("stall_vld1", bus.o_stage_vld, 5'b00111);
        tick(1);
        bus.i_mem_stall = 0;
        @(negedge clk);
        check("stall_vld2", bus.o_stage_vld, 5'b00111);
        tick(1);
        @(negedge clk);
        check("unstall_vld", bus.o_stage_vld, 5'b01110);
        tick(6);

        // Flush ignored when EX empty
        issue(4'd1, 1, 0, 0, 0, 0, w);
        bus.i_flush = 1;
        @(negedge clk);
        check("flush_ign_rdy", bus.o_issue_rdy, 1);
        tick(1);
        bus.i_flush = 0;
        @(negedge clk);
        check("flush_ign_vld", bus.o_stage_vld, 5'b00010);
        tick(6);

        // Flush with 4 writers of r3
        for (int i = 0; i < 4; i++) issue(4'd3, 1, 0, 0, 0, 0, w);
        bus.i_flush = 1;
        @(negedge clk);
        check("flush_cnt_before", bus.dbg_cnt[3], 4);
        check("flush_rdy", bus.o_issue_rdy, 0);
        tick(1);
        bus.i_flush = 0;
        @(negedge clk);
        check("flush_vld", bus.o_stage_vld, 5'b10000);
        check("flush_cnt_after", bus.dbg_cnt[3], 1);
        check("flush_wb_dst", bus.o_wb_dst, 3);
        tick(1);
        @(negedge clk);
        check("flush_cnt_drained", bus.dbg_cnt[3], 0);
        tick(4);

        // Flush + stall + retire of r3, 5 writers in flight
        for (int i = 0; i < 5; i++) issue(4'd3, 1, 0, 0, 0, 0, w);
        bus.i_flush = 1; bus.i_mem_stall = 1;
        @(negedge clk);
        check("fs_cnt_before", bus.dbg_cnt[3], 5);
        check("fs_ld", bus.o_stage_ld, 5'b11111);
        tick(1);
        bus.i_flush = 0; bus.i_mem_stall = 0;
        @(negedge clk);
        check("fs_vld", bus.o_stage_vld, 5'b10000);
        check("fs_cnt_after", bus.dbg_cnt[3], 1);
        tick(1);
        @(negedge clk);
        check("fs_cnt_drained", bus.dbg_cnt[3], 0);
        tick(4);

        // Reset mid-flight with 3 writers of r1
        for (int i = 0; i < 3; i++) issue(4'd1, 1, 0, 0, 0, 0, w);
        rst = 0;
        #1;
        check("midrst_vld", bus.o_stage_vld, 0);
        check("midrst_cnt1", bus.dbg_cnt[1], 0);
        check("midrst_rdy", bus.o_issue_rdy, 0);
        check("midrst_ld", bus.o_stage_ld, 0);
        tick(1);
        rst = 1;
        tick(2);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
